ev_timer_arbiter: RTL

- Shares one event_timestamper between N_CLI requesters.
- Owns the ID space: allocates a free ID to each client on start, checks end requests against ownership, and routes each timestamper result back to the owning client.
- Sits directly in front of event_timestamper: drives its start/end channels and consumes its out channel.

---
 rtl/ev_timer_arbiter_if.sv | 50 +++++
 rtl/ev_timer_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/ev_timer_arbiter_if.sv
// Bundle of client, timestamper and result channels around ev_timer_arbiter.
// slave = arbiter view; master = the surrounding clients/timestamper/consumer.
interface ev_timer_arbiter_if #(
  parameter int N_CLI = 4,
  parameter int ID_W  = 3,
  parameter int TS_W  = 8
);
  localparam int CLI_W = $clog2(N_CLI);

  logic [N_CLI-1:0]      cli_start_valid;
  logic [N_CLI-1:0]      cli_start_ready;
  logic [ID_W-1:0]       cli_start_id;
  logic [N_CLI-1:0]      cli_end_valid;
  logic [N_CLI*ID_W-1:0] cli_end_id;
  logic [N_CLI-1:0]      cli_end_ready;
  logic                  ts_start_valid;
  logic                  ts_start_ready;
  logic [ID_W-1:0]       ts_start_id;
  logic                  ts_end_valid;
  logic                  ts_end_ready;
  logic [ID_W-1:0]       ts_end_id;
  logic                  ts_out_valid;
  logic                  ts_out_ready;
  logic [ID_W-1:0]       ts_out_id;
  logic [TS_W-1:0]       ts_out_delta;
  logic                  res_valid;
  logic                  res_ready;
  logic [CLI_W-1:0]      res_client;
  logic [ID_W-1:0]       res_id;
  logic [TS_W-1:0]       res_delta;
  logic                  end_err;
  logic                  pool_full;
  logic [ID_W:0]         alloc_cnt;

  modport slave (
    input  cli_start_valid, cli_end_valid, cli_end_id, ts_start_ready, ts_end_ready,
           ts_out_valid, ts_out_id, ts_out_delta, res_ready,
    output cli_start_ready, cli_start_id, cli_end_ready, ts_start_valid, ts_start_id,
           ts_end_valid, ts_end_id, ts_out_ready, res_valid, res_client, res_id,
           res_delta, end_err, pool_full, alloc_cnt
  );

  modport master (
    output cli_start_valid, cli_end_valid, cli_end_id, ts_start_ready, ts_end_ready,
           ts_out_valid, ts_out_id, ts_out_delta, res_ready,
    input  cli_start_ready, cli_start_id, cli_end_ready, ts_start_valid, ts_start_id,
           ts_end_valid, ts_end_id, ts_out_ready, res_valid, res_client, res_id,
           res_delta, end_err, pool_full, alloc_cnt
  );
endinterface

// File: rtl/ev_timer_arbiter.sv
// Shares one event_timestamper between N_CLI clients: owns the ID pool,
// round-robins start/end requests, checks end ownership and routes results.
module ev_timer_arbiter #(
  parameter int N_CLI = 4,
  parameter int ID_W  = 3,
  parameter int TS_W  = 8
) (
  input logic               clk,
  input logic               rst,
  ev_timer_arbiter_if.slave bus
);
  localparam int CLI_W = $clog2(N_CLI);
  localparam int NID   = 2**ID_W;

  logic [NID-1:0]   free_mask;
  logic [CLI_W-1:0] owner [NID];
  logic [CLI_W-1:0] rr_start_ptr;
  logic [CLI_W-1:0] rr_end_ptr;
  logic [ID_W:0]    alloc_cnt;
  logic             end_err;

  logic [ID_W-1:0]  free_id;
  logic             pool_full;
  logic             s_found, e_found, e_legal;
  logic [CLI_W-1:0] s_win, e_win;
  logic [ID_W-1:0]  e_id;
  logic             start_hs, end_fwd_hs, end_drop, ret_hs;
  int unsigned      s_idx, e_idx;

  always_comb begin
    pool_full = (free_mask == '0);
    free_id   = '0;
    // Scan from the top so the last hit, the lowest free ID, wins.
    for (int unsigned i = 0; i < NID; i++)
      if (free_mask[NID-1-i]) free_id = ID_W'(NID-1-i);

    s_found = 1'b0;
    s_win   = '0;
    s_idx   = 0;
    e_found = 1'b0;
    e_win   = '0;
    e_idx   = 0;
    e_id    = '0;
    for (int unsigned i = 0; i < N_CLI; i++) begin
      s_idx = (32'(rr_start_ptr) + i) % N_CLI;
      if (!s_found && bus.cli_start_valid[s_idx]) begin
        s_found = 1'b1;
        s_win   = CLI_W'(s_idx);
      end
      e_idx = (32'(rr_end_ptr) + i) % N_CLI;
      if (!e_found && bus.cli_end_valid[e_idx]) begin
        e_found = 1'b1;
        e_win   = CLI_W'(e_idx);
        e_id    = bus.cli_end_id[e_idx*ID_W +: ID_W];
      end
    end
    e_legal = e_found && !free_mask[e_id] && (owner[e_id] == e_win);
  end

  always_comb begin
    bus.ts_start_valid  = s_found && !pool_full;
    bus.ts_start_id     = free_id;
    bus.cli_start_id    = free_id;
    bus.cli_start_ready = '0;
    if (s_found && !pool_full)
      bus.cli_start_ready[s_win] = bus.ts_start_ready;
    start_hs = bus.ts_start_valid && bus.ts_start_ready;

    // Illegal ends are acknowledged immediately and never reach the timestamper.
    bus.ts_end_valid  = e_legal;
    bus.ts_end_id     = e_id;
    bus.cli_end_ready = '0;
    if (e_found)
      bus.cli_end_ready[e_win] = e_legal ? bus.ts_end_ready : 1'b1;
    end_fwd_hs = e_legal && bus.ts_end_ready;
    end_drop   = e_found && !e_legal;

    bus.res_valid    = bus.ts_out_valid;
    bus.ts_out_ready = bus.res_ready;
    bus.res_id       = bus.ts_out_id;
    bus.res_delta    = bus.ts_out_delta;
    bus.res_client   = owner[bus.ts_out_id];
    ret_hs = bus.ts_out_valid && bus.res_ready;

    bus.end_err   = end_err;
    bus.pool_full = pool_full;
    bus.alloc_cnt = alloc_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_mask    <= '1;
      for (int unsigned i = 0; i < NID; i++) owner[i] <= '0;
      rr_start_ptr <= '0;
      rr_end_ptr   <= '0;
      alloc_cnt    <= '0;
      end_err      <= 1'b0;
    end else begin
      end_err <= end_drop;
      // Retired and allocated IDs always differ, so both updates can land together.
      if (ret_hs) free_mask[bus.ts_out_id] <= 1'b1;
      if (start_hs) begin
        free_mask[free_id] <= 1'b0;
        owner[free_id]     <= s_win;
        rr_start_ptr       <= CLI_W'((32'(s_win) + 1) % N_CLI);
      end
      if (end_fwd_hs || end_drop)
        rr_end_ptr <= CLI_W'((32'(e_win) + 1) % N_CLI);
      if (start_hs && !ret_hs)
        alloc_cnt <= alloc_cnt + 1'b1;
      else if (!start_hs && ret_hs)
        alloc_cnt <= alloc_cnt - 1'b1;

      assert (!(start_hs && !ret_hs && alloc_cnt == (ID_W+1)'(NID)));
      assert (!(ret_hs && !start_hs && alloc_cnt == '0));
    end
  end
endmodule
